// File: rtl/mean_filter.sv
// Streaming 3x3 box filter for AXI4-Stream video. The window is causal (ends at the
// current pixel) with top/left edge replication; one output beat per accepted input.
`timescale 1ns/1ps
module mean_filter #(
  parameter int DATA_WIDTH   = 8,
  parameter int WINDOW_SIZE  = 3,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready
);
  localparam int STAGES = 3;
  localparam int SW     = DATA_WIDTH + 4;
  localparam int CW     = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
  localparam int RW     = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

  generate
    if (WINDOW_SIZE != 3) begin : g_bad_window
      $error("mean_filter: only WINDOW_SIZE = 3 is supported");
    end
  endgenerate

  typedef struct packed {
    logic last;
    logic user;
  } side_t;

  logic                  accept, adv;
  logic [CW-1:0]         col, cur_col;
  logic [RW-1:0]         row, cur_row;
  logic                  eol, last_row;
  logic [DATA_WIDTH-1:0] lb1 [FRAME_WIDTH];
  logic [DATA_WIDTH-1:0] lb2 [FRAME_WIDTH];
  logic [DATA_WIDTH-1:0] lb1_rd, lb2_rd;
  logic [2:0][DATA_WIDTH-1:0]      colv;
  logic [2:0][2:0][DATA_WIDTH-1:0] win;   // win[col age][row age]
  logic [SW-1:0]         win_sum, s2_sum;
  logic [STAGES:1]       vld_pipe;
  side_t [STAGES:1]      side_pipe;
  side_t                 side_in;

  // The whole pipeline advances only when downstream can take a beat.
  assign s_axis_tready = rst_n & m_axis_tready;
  assign accept        = s_axis_tvalid & s_axis_tready & in_valid;
  assign adv           = m_axis_tready;

  // SOF overrides the tracked position for the beat that carries it.
  assign cur_col  = s_axis_tuser ? '0 : col;
  assign cur_row  = s_axis_tuser ? '0 : row;
  assign eol      = s_axis_tlast | (cur_col == CW'(FRAME_WIDTH - 1));
  assign last_row = (cur_row == RW'(FRAME_HEIGHT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (eol) begin
        col <= '0;
        row <= last_row ? '0 : cur_row + RW'(1);
      end else begin
        col <= cur_col + CW'(1);
        row <= cur_row;
      end
    end
  end

  assign lb1_rd = lb1[cur_col];
  assign lb2_rd = lb2[cur_col];

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[cur_col] <= s_axis_tdata;
      lb2[cur_col] <= lb1_rd;
    end
  end

  // Missing rows above the frame replicate row 0.
  always_comb begin
    colv[0] = s_axis_tdata;
    colv[1] = (cur_row == '0) ? s_axis_tdata : lb1_rd;
    colv[2] = (cur_row == '0)     ? s_axis_tdata :
              (cur_row == RW'(1)) ? lb1_rd : lb2_rd;
  end

  // S1: window shift; missing columns left of the frame replicate column 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win <= '0;
    end else if (accept) begin
      win[0] <= colv;
      if (cur_col == '0) begin
        win[1] <= colv;
        win[2] <= colv;
      end else if (cur_col == CW'(1)) begin
        win[1] <= win[0];
        win[2] <= win[0];
      end else begin
        win[1] <= win[0];
        win[2] <= win[1];
      end
    end
  end

  always_comb begin
    win_sum = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        win_sum += SW'(win[i][j]);
  end

  assign side_in = accept ? '{last: s_axis_tlast, user: s_axis_tuser} : '0;

  // S2: sum, S3: round-half-up divide by 9 into the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe     <= '0;
      side_pipe    <= '0;
      s2_sum       <= '0;
      m_axis_tdata <= '0;
    end else if (adv) begin
      vld_pipe     <= {vld_pipe[STAGES-1:1], accept};
      side_pipe    <= {side_pipe[STAGES-1:1], side_in};
      s2_sum       <= win_sum;
      m_axis_tdata <= DATA_WIDTH'((s2_sum + SW'(4)) / SW'(9));
    end
  end

  assign m_axis_tvalid = vld_pipe[STAGES];
  assign m_axis_tlast  = side_pipe[STAGES].last;
  assign m_axis_tuser  = side_pipe[STAGES].user;

endmodule

// File: tb/tb_mean_filter.sv
// Directed bench for mean_filter on a small 8x6 frame: reset, constant, gradient,
// impulse, rounding, backpressure, latency, input enable and mid-frame reset.
`timescale 1ns/1ps
module tb_mean_filter;
  localparam int DW = 8, FW = 8, FH = 6, NPIX = FW * FH;

  logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tuser = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic          m_axis_tready = 1'b1;

  always #5 clk = ~clk;

  mean_filter #(.DATA_WIDTH(DW), .WINDOW_SIZE(3), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready)
  );

  int img [FH][FW];
  int nvec = 0, nerr = 0;
  logic [DW-1:0] q_data [$];
  logic          q_last [$];
  logic          q_user [$];

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (m_axis_tvalid && m_axis_tready) begin
      q_data.push_back(m_axis_tdata);
      q_last.push_back(m_axis_tlast);
      q_user.push_back(m_axis_tuser);
    end

  // Straightforward 2-D reference: clamp negative indices, round half up.
  function automatic int model(input int r, input int c);
    int s = 0;
    for (int dr = -2; dr <= 0; dr++)
      for (int dc = -2; dc <= 0; dc++)
        s += img[(r + dr < 0) ? 0 : r + dr][(c + dc < 0) ? 0 : c + dc];
    return (s + 4) / 9;
  endfunction

  task automatic clear_q();
    q_data.delete(); q_last.delete(); q_user.delete();
  endtask

  task automatic fill(input int kind);
    for (int r = 0; r < FH; r++)
      for (int c = 0; c < FW; c++)
        case (kind)
          0:       img[r][c] = 100;
          1:       img[r][c] = (r + c) % 256;
          default: img[r][c] = 0;
        endcase
  endtask

  task automatic send_pix(input int d, input bit last, input bit user);
    bit done = 0;
    s_axis_tdata = DW'(d); s_axis_tlast = last; s_axis_tuser = user;
    s_axis_tvalid = 1'b1; in_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(posedge clk);
      if (s_axis_tready) done = 1;
    end
    if (!done) chk("send_timeout", 0, 1);
    #1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
  endtask

  task automatic send_frame();
    for (int r = 0; r < FH; r++)
      for (int c = 0; c < FW; c++)
        send_pix(img[r][c], c == FW - 1, r == 0 && c == 0);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag);
    int nl = 0, nbad = 0, nu = 0;
    chk({tag, "_count"}, q_data.size(), NPIX);
    if (q_data.size() == NPIX) begin
      for (int i = 0; i < NPIX; i++) begin
        chk($sformatf("%s(%0d,%0d)", tag, i / FW, i % FW), int'(q_data[i]), model(i / FW, i % FW));
        if (q_last[i]) begin
          nl++;
          if (i % FW != FW - 1) nbad++;
        end
        if (q_user[i]) nu++;
      end
      chk({tag, "_tlast_cnt"}, nl, FH);
      chk({tag, "_tlast_pos"}, nbad, 0);
      chk({tag, "_tuser_cnt"}, nu, 1);
      chk({tag, "_tuser_first"}, int'(q_user[0]), 1);
    end
  endtask

  task automatic spot(input string tag, input int r, input int c, input int exp);
    if (q_data.size() > r * FW + c) chk(tag, int'(q_data[r * FW + c]), exp);
    else chk({tag, "_missing"}, q_data.size(), r * FW + c + 1);
  endtask

  initial begin
    logic [DW-1:0] h_d;
    logic          h_v, h_l;
    int            nz;

    // Reset state
    #12;
    chk("rst_tvalid", int'(m_axis_tvalid), 0);
    chk("rst_tdata",  int'(m_axis_tdata), 0);
    chk("rst_tlast",  int'(m_axis_tlast), 0);
    chk("rst_tuser",  int'(m_axis_tuser), 0);
    chk("rst_tready", int'(s_axis_tready), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    #1 chk("tready_after_rst", int'(s_axis_tready), 1);

    // Constant frame
    fill(0); clear_q(); send_frame();
    check_frame("const");
    spot("const_first", 0, 0, 100);
    spot("const_last", FH - 1, FW - 1, 100);

    // Gradient: hand values (0,0)=0 (0,1)=0 (1,1)=1, r,c>=2 -> r+c-2
    fill(1); clear_q(); send_frame();
    check_frame("grad");
    spot("grad_0_0", 0, 0, 0);
    spot("grad_0_1", 0, 1, 0);
    spot("grad_1_1", 1, 1, 1);
    spot("grad_4_5", 4, 5, 7);
    spot("grad_5_7", 5, 7, 10);

    // Impulse 255 at (2,2): 259/9 -> 28 over rows/cols 2..4
    fill(2); img[2][2] = 255; clear_q(); send_frame();
    check_frame("imp");
    spot("imp_2_2", 2, 2, 28);
    spot("imp_3_3", 3, 3, 28);
    spot("imp_4_4", 4, 4, 28);
    spot("imp_5_5", 5, 5, 0);
    spot("imp_1_2", 1, 2, 0);
    nz = 0;
    foreach (q_data[i]) if (q_data[i] != 0) nz++;
    chk("imp_nonzero", nz, 9);

    // Rounding: sum 13 -> 1, sum 14 -> 2
    fill(2); img[2][2] = 13; img[2][6] = 14; clear_q(); send_frame();
    check_frame("rnd");
    spot("rnd_sum13", 3, 3, 1);
    spot("rnd_sum14", 3, 7, 2);
    spot("rnd_sum14b", 2, 6, 2);
    spot("rnd_gap", 2, 5, 0);

    // Backpressure: 10-cycle stall mid-line must not change the output sequence
    fill(1); clear_q();
    fork
      send_frame();
      begin
        repeat (FW + 3) @(posedge clk);
        #1 m_axis_tready = 1'b0;
        @(negedge clk);
        h_d = m_axis_tdata; h_v = m_axis_tvalid; h_l = m_axis_tlast;
        chk("bp_tready_low", int'(s_axis_tready), 0);
        chk("bp_valid_held", int'(h_v), 1);
        for (int k = 1; k < 10; k++) begin
          @(negedge clk);
          chk("bp_tready_low", int'(s_axis_tready), 0);
          chk("bp_tdata_stable", int'(m_axis_tdata), int'(h_d));
          chk("bp_tvalid_stable", int'(m_axis_tvalid), int'(h_v));
          chk("bp_tlast_stable", int'(m_axis_tlast), int'(h_l));
        end
        @(posedge clk);
        #1 m_axis_tready = 1'b1;
        #1 chk("bp_tready_back", int'(s_axis_tready), 1);
      end
    join
    check_frame("bp");

    // Latency: one accepted pixel appears after exactly three clocks
    clear_q();
    s_axis_tdata = 8'd50; s_axis_tuser = 1'b1; s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0;
    @(negedge clk) chk("lat_clk1", int'(m_axis_tvalid), 0);
    @(negedge clk) chk("lat_clk2", int'(m_axis_tvalid), 0);
    @(negedge clk) chk("lat_clk3", int'(m_axis_tvalid), 1);
    chk("lat_data", int'(m_axis_tdata), 50);
    chk("lat_tuser", int'(m_axis_tuser), 1);
    @(negedge clk) chk("lat_clk4", int'(m_axis_tvalid), 0);

    // in_valid=0 blocks accepts; next real pixel lands at (0,1): (50+50+20)*3=360 -> 40
    clear_q();
    @(posedge clk); #1;
    s_axis_tdata = 8'd200; s_axis_tvalid = 1'b1; in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 s_axis_tvalid = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("inv_no_output", q_data.size(), 0);
    send_pix(20, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 chk("inv_count", q_data.size(), 1);
    if (q_data.size() > 0) chk("inv_position", int'(q_data[0]), 40);

    // Mid-frame reset drops outputs without waiting for a clock
    fill(1); clear_q();
    for (int i = 0; i < FW + 4; i++) send_pix(img[i / FW][i % FW], i % FW == FW - 1, i == 0);
    @(negedge clk) chk("mrst_pre_valid", int'(m_axis_tvalid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_tvalid", int'(m_axis_tvalid), 0);
    chk("mrst_tdata", int'(m_axis_tdata), 0);
    chk("mrst_tready", int'(s_axis_tready), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_q(); send_frame();
    check_frame("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mean_filter.md
Name: mean_filter

Overview:
- Streaming 3x3 box (mean) filter for 8-bit grayscale video on AXI4-Stream, one pixel per clock.
- Sits between a pixel source and downstream image processing.
- Emits exactly one output pixel per accepted input pixel, with the same frame size and sideband (tlast/tuser) alignment.
- The window is causal: it ends at the current pixel, so output is geometrically offset by (+1,+1). The offset is intentional.

Parameters:
- DATA_WIDTH, 8: pixel width in bits.
- WINDOW_SIZE, 3: window edge length. Only 3 is supported; any other value is an elaboration error.
- FRAME_WIDTH, 640: pixels per line; sets line-buffer depth.
- FRAME_HEIGHT, 512: lines per frame.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  global input enable; a beat is accepted only when it is 1.
- s_axis_tdata  in  DATA_WIDTH  input pixel.
- s_axis_tvalid  in  1  input valid.
- s_axis_tlast  in  1  last pixel of line.
- s_axis_tuser  in  1  first pixel of frame (SOF).
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  DATA_WIDTH  filtered pixel.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  end of line, delayed with its pixel.
- m_axis_tuser  out  1  SOF, delayed with its pixel.
- m_axis_tready  in  1  downstream ready.

Behaviour:
Reset and handshake:
- Reset: one clock domain; rst_n is asynchronous, active-low.
- Reset values: all m_axis_* outputs 0, row/col counters 0, pipeline valids 0. Line-buffer contents need not be cleared.
- s_axis_tready = rst_n AND m_axis_tready (combinational).
- Accept = s_axis_tvalid AND s_axis_tready AND in_valid.

Position tracking:
- Accepted beat with tuser=1 forces position (row 0, col 0).
- After each accept: col increments. On tlast, or col = FRAME_WIDTH-1, col wraps to 0 and row increments.
- Row wraps to 0 after FRAME_HEIGHT-1.

Window and arithmetic:
- Two line buffers (FRAME_WIDTH x DATA_WIDTH) hold the previous two lines.
- A 3-column shift register forms the window.
- Output for input position (r,c) = rounded mean of rows r-2..r and cols c-2..c.
- Any negative index is clamped to 0 (replicate top/left edge). At r=0 all three rows use row 0; at r=1 the rows are 0,0,1. Columns are clamped the same way.
- Sum width is DATA_WIDTH+4 (unsigned).
- Result = floor((sum+4)/9), i.e. round half up. Maximum result is 255, so no saturation is needed.

Pipeline and latency:
- Three register stages:
  - S1: line-buffer read / window shift.
  - S2: 9-term sum.
  - S3: divide and output register.
- Latency is 3 clocks from accept to m_axis_tvalid while m_axis_tready=1.
- tlast/tuser travel through the stages alongside the data.
- Backpressure: when m_axis_tready=0, all stages, counters and line buffers hold and m_axis_* stay stable. No beats are lost or duplicated.
- Bubbles (no accept) propagate as tvalid=0 without disturbing window state.

Boundaries:
- Frame of FRAME_WIDTH*FRAME_HEIGHT inputs yields exactly that many outputs, FRAME_HEIGHT tlast pulses, and one tuser.
- tuser arriving mid-frame restarts row/col at 0. Pixels already in flight complete unchanged.
- Reset mid-frame: outputs drop to 0 immediately. The next frame must start with tuser.

Test Plan:
- Constant frame of 100 (640x512, continuous, m_axis_tready=1) -> every output 100; 327680 outputs; 512 tlast; a single tuser on the first output.
- Gradient (r+c)%256 -> outputs: (0,0)=0, (0,1)=0, (1,1)=1. For r,c>=2 in the non-wrapping region, output = r+c-2 (e.g. (10,20)=28).
- Impulse 255 at (5,5), all else 0 -> outputs at rows 5..7, cols 5..7 = 28; every other output 0.
- Rounding: windows with sum 13 -> 1, sum 14 -> 2.
- Backpressure: drop m_axis_tready for 10 cycles mid-line -> s_axis_tready low for the same cycles, m_axis_* held stable, output sequence identical to the no-stall run.
- Latency/enable: single pixel accepted -> m_axis_tvalid exactly 3 cycles later. in_valid=0 with s_axis_tvalid=1 -> no accept, no counter change. rst_n low mid-frame -> m_axis_tvalid=0 asynchronously.
